adc_serial_reader: RTL and testbench
====================================

Name: adc_serial_reader

Overview:
- Periodically triggers a conversion on an external 10-bit serial ADC (TLC1549-class: CSn, SCLK, SDO, MSB-first) and shifts in the result.
- Presents the result as a registered 10-bit word with a one-cycle valid strobe.
- Sits directly upstream of the seven-segment numeric display driver; its Data output feeds that block's 10-bit Data input.

Parameters:
- CLK_DIV, 8, CLK cycles per SCLK half-period; also the CSn-low-to-first-SCLK setup length (>=1).
- LEAD_BITS, 2, SCLK cycles clocked before the MSB (ADC sample/null phase); their SDO values are discarded.
- SAMPLE_PERIOD, 50000, CLK cycles between conversion-start ticks.
- NBITS, 10, result width.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  asynchronous active-low reset
- Enable  in  1  high = periodic conversions run
- ADC_SDO  in  1  serial data from ADC
- ADC_CSn  out  1  ADC chip select, active low
- ADC_SCLK  out  1  ADC serial clock, idles low
- Data  out  NBITS  last completed result, registered
- Data_Valid  out  1  one-cycle pulse when Data updates
- Busy  out  1  high while a conversion frame is in progress

Behaviour:
- Reset (asynchronous, any time including mid-frame): ADC_CSn=1, ADC_SCLK=0, Data=0, Data_Valid=0, Busy=0, timer=0, state=IDLE, shift register=0.
- Sample timer: counts 0..SAMPLE_PERIOD-1 while Enable=1 and wraps. The tick is the cycle in which count==SAMPLE_PERIOD-1. Enable=0 clears the timer and holds it at 0.
- States: IDLE, SETUP, SCLK_LO, SCLK_HI, DONE.
- IDLE:
  - On tick, go to SETUP. ADC_CSn=0 and Busy=1 from the next cycle.
  - A tick arriving while not in IDLE is dropped. Constraint: SAMPLE_PERIOD > frame length.
- SETUP: CLK_DIV cycles with SCLK low, then SCLK_LO.
- SCLK_LO: CLK_DIV cycles with SCLK low. On the CLK edge that ends it, drive SCLK high and sample ADC_SDO. SDO has been stable for >=CLK_DIV cycles, so no synchroniser is used.
- SCLK_HI: CLK_DIV cycles with SCLK high, then SCLK falls.
  - If LEAD_BITS+NBITS bits are done, go to DONE; else go to SCLK_LO.
- Bit handling:
  - The bit counter counts 0..LEAD_BITS+NBITS-1.
  - Samples with index < LEAD_BITS are discarded.
  - Later samples shift in MSB first: shift <= {shift[NBITS-2:0], SDO}.
- DONE (exactly 1 cycle): ADC_CSn=1, Busy=0, ADC_SCLK=0, Data<=shift, Data_Valid=1. Next state IDLE.
- Frame length (ADC_CSn low): CLK_DIV + 2*CLK_DIV*(LEAD_BITS+NBITS) cycles. Defaults: 8 + 16*12 = 200 cycles.
- Latency: tick to Data_Valid = frame length + 1 cycles.
- Enable falling mid-frame: the frame completes normally and Data_Valid fires. No new frame starts.
- Data holds its value between strobes. Data_Valid never asserts on two consecutive cycles.

Optional Feature:
- Macro ADC_AVG_EN.
- Defined:
  - A 12-bit accumulator sums 4 consecutive results.
  - On the 4th DONE: Data <= (acc + result) >> 2 (truncating), Data_Valid pulses, accumulator clears.
  - Data_Valid does not pulse on DONE cycles 1-3.
  - The accumulator and the 2-bit frame counter reset to 0 on RSTn and when Enable=0.
- Undefined: no accumulator. Data and Data_Valid update on every DONE.

Decomposition:
- Shared package adc_pkg holds:
  - state enumeration (IDLE, SETUP, SCLK_LO, SCLK_HI, DONE)
  - ADC_NBITS=10
  - default CLK_DIV / LEAD_BITS / SAMPLE_PERIOD constants
- Sub-module adc_sample_timer (counter plus tick output, Enable-gated) is natural and is instantiated once.
- The FSM, shifter and optional averager stay in the top module.

Test Plan:
- CLK_DIV=2, LEAD_BITS=2, SAMPLE_PERIOD=100; ADC model returns 10'h2A5 → ADC_CSn low for exactly 50 cycles, 12 SCLK rising edges, Data=10'h2A5, Data_Valid high 1 cycle at tick+51.
- Model returns 10'h3FF, then 10'h000, then 10'h155 on successive frames → Data follows each value; Data_Valid strobes spaced exactly 100 cycles apart.
- RSTn pulsed low at SCLK edge 5 → ADC_CSn=1, SCLK=0, Data=0 immediately (async). After release, the first frame starts at timer count 99 and no partial Data is produced.
- Enable dropped at SCLK edge 6 → frame completes with a valid strobe; no further ADC_CSn activity for 500 cycles.
- SAMPLE_PERIOD=40 (< frame length 50) → every other tick is dropped; frames never overlap; Busy never has a gap shorter than 1 cycle inside a frame.
- ADC_AVG_EN defined; results 100, 101, 102, 104 → one Data_Valid after the 4th frame, Data=101 (407>>2); no strobes after frames 1-3.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the serial ADC reader.
//   - adc_state_e : conversion frame state encoding
//   - ADC_NBITS   : ADC result width
//   - default timing constants for CLK_DIV / LEAD_BITS / SAMPLE_PERIOD
//   - adc_cnt_width(): counter width helper that never returns zero
package adc_pkg;

    localparam int unsigned ADC_NBITS                 = 10;
    localparam int unsigned ADC_CLK_DIV_DEFAULT       = 8;
    localparam int unsigned ADC_LEAD_BITS_DEFAULT     = 2;
    localparam int unsigned ADC_SAMPLE_PERIOD_DEFAULT = 50000;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSclkLo,
        StSclkHi,
        StDone
    } adc_state_e;

    // Width of a counter that must hold 0..n-1; at least one bit.
    function automatic int unsigned adc_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_serial_reader_if.sv
// adc_serial_reader_if: three-wire serial ADC bus (TLC1549-class).
//   ADC_CSn  : chip select, active low   (reader -> ADC)
//   ADC_SCLK : serial clock, idles low   (reader -> ADC)
//   ADC_SDO  : serial data, MSB first    (ADC -> reader)
// Modports: master = the reader, slave = the ADC.
interface adc_serial_reader_if;

    logic ADC_CSn;
    logic ADC_SCLK;
    logic ADC_SDO;

    modport master (
        output ADC_CSn,
        output ADC_SCLK,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CSn,
        input  ADC_SCLK,
        output ADC_SDO
    );

endinterface

// File: rtl/adc_sample_timer.sv
// adc_sample_timer: free-running conversion-start timer.
//   CLK        : system clock
//   RSTn       : asynchronous active-low reset
//   enable_i   : high = count 0..SAMPLE_PERIOD-1 and wrap; low = clear and hold at 0
//   tick_o     : high in the cycle where the count equals SAMPLE_PERIOD-1
module adc_sample_timer
    import adc_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = ADC_SAMPLE_PERIOD_DEFAULT
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned     CntW    = adc_cnt_width(SAMPLE_PERIOD);
    localparam logic [CntW-1:0] LastCnt = CntW'(SAMPLE_PERIOD - 1);

    logic [CntW-1:0] count_q, count_d;

    assign tick_o = enable_i && (count_q == LastCnt);

    always_comb begin
        count_d = count_q;
        if (!enable_i || tick_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: periodically runs a conversion frame on a 10-bit serial ADC
// and presents the result as a registered word with a one-cycle valid strobe.
//   CLK        : system clock
//   RSTn       : asynchronous active-low reset
//   Enable     : high = periodic conversions run
//   adc        : serial ADC bus (master side: ADC_CSn, ADC_SCLK out; ADC_SDO in)
//   Data       : last completed result, registered, held between strobes
//   Data_Valid : one-cycle pulse when Data updates
//   Busy       : high while a conversion frame is in progress (ADC_CSn low)
// Frame: CLK_DIV setup cycles, then LEAD_BITS+NBITS SCLK periods of 2*CLK_DIV cycles.
// SDO is sampled on the CLK edge that raises SCLK; the first LEAD_BITS samples are
// dropped and the rest shift in MSB first.
// Optional build macro ADC_AVG_EN: average four consecutive results and strobe
// once per four frames.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV       = ADC_CLK_DIV_DEFAULT,
    parameter int unsigned LEAD_BITS     = ADC_LEAD_BITS_DEFAULT,
    parameter int unsigned SAMPLE_PERIOD = ADC_SAMPLE_PERIOD_DEFAULT,
    parameter int unsigned NBITS         = ADC_NBITS
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       Enable,
    adc_serial_reader_if.master        adc,
    output logic [NBITS-1:0]           Data,
    output logic                       Data_Valid,
    output logic                       Busy
);

    localparam int unsigned     TotalBits = LEAD_BITS + NBITS;
    localparam int unsigned     DivW      = adc_cnt_width(CLK_DIV);
    localparam int unsigned     BitW      = adc_cnt_width(TotalBits);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(TotalBits - 1);
    localparam logic [BitW-1:0] LeadBits  = BitW'(LEAD_BITS);

    adc_state_e       state_q;
    logic [DivW-1:0]  div_q;
    logic [BitW-1:0]  bit_q;
    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] data_q;
    logic             csn_q;
    logic             sclk_q;
    logic             valid_q;
    logic             busy_q;
    logic             tick;
    logic             div_done;

`ifdef ADC_AVG_EN
    localparam int unsigned AccW = NBITS + 2;

    logic [AccW-1:0] acc_q;
    logic [1:0]      frame_q;
    logic [AccW-1:0] acc_sum;

    // Running sum including the result that is completing this cycle.
    assign acc_sum = acc_q + AccW'(shift_q);
`endif

    adc_sample_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .enable_i (Enable),
        .tick_o   (tick)
    );

    assign div_done = (div_q == DivLast);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q   <= '0;
            frame_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef ADC_AVG_EN
            if (!Enable) begin
                acc_q   <= '0;
                frame_q <= '0;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    // Ticks seen in any other state are simply ignored.
                    if (tick) begin
                        state_q <= StSetup;
                        csn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end

                StSetup: begin
                    if (div_done) begin
                        state_q <= StSclkLo;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                StSclkLo: begin
                    if (div_done) begin
                        state_q <= StSclkHi;
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        // SDO has been stable for CLK_DIV cycles here, so no synchroniser.
                        if (bit_q >= LeadBits) begin
                            shift_q <= {shift_q[NBITS-2:0], adc.ADC_SDO};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                StSclkHi: begin
                    if (div_done) begin
                        sclk_q <= 1'b0;
                        div_q  <= '0;
                        if (bit_q == BitLast) begin
                            // Result is published on entry so Data/Data_Valid are
                            // visible during the single DONE cycle.
                            state_q <= StDone;
                            csn_q   <= 1'b1;
                            busy_q  <= 1'b0;
`ifdef ADC_AVG_EN
                            if (Enable) begin
                                if (frame_q == 2'd3) begin
                                    data_q  <= acc_sum[AccW-1:2];
                                    valid_q <= 1'b1;
                                    acc_q   <= '0;
                                    frame_q <= '0;
                                end else begin
                                    acc_q   <= acc_sum;
                                    frame_q <= frame_q + 1'b1;
                                end
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            state_q <= StSclkLo;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign adc.ADC_CSn  = csn_q;
    assign adc.ADC_SCLK = sclk_q;
    assign Data         = data_q;
    assign Data_Valid   = valid_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: bench for adc_serial_reader.
// Main DUT: CLK_DIV=2, LEAD_BITS=2, SAMPLE_PERIOD=100, fed by a behavioural ADC model.
// Second DUT: SAMPLE_PERIOD=40 (shorter than a frame), SDO tied high.
// Honours ADC_AVG_EN to pick expected values for the averaging build.
module tb_adc_serial_reader;
    import adc_pkg::*;

    localparam int unsigned CD    = 2;
    localparam int unsigned LB    = 2;
    localparam int unsigned SP    = 100;
    localparam int unsigned SP2   = 40;
    localparam int unsigned NB    = ADC_NBITS;
    localparam int unsigned FRAME = CD + 2 * CD * (LB + NB);
    localparam int unsigned NVEC  = 12;
`ifdef ADC_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    typedef struct {
        logic [NB-1:0] word;
        logic [NB-1:0] exp_data;
        int            exp_strobes;
        int            exp_gap;
    } vec_t;

    vec_t tab [NVEC];

    logic          clk;
    logic          rstn;
    logic          en;
    logic          en2;
    logic [NB-1:0] data, data2;
    logic          valid, valid2, busy, busy2;

    int vectors     = 0;
    int miscompares = 0;

    adc_serial_reader_if bus ();
    adc_serial_reader_if bus2 ();

    adc_serial_reader #(
        .CLK_DIV       (CD),
        .LEAD_BITS     (LB),
        .SAMPLE_PERIOD (SP),
        .NBITS         (NB)
    ) dut (
        .CLK        (clk),
        .RSTn       (rstn),
        .Enable     (en),
        .adc        (bus),
        .Data       (data),
        .Data_Valid (valid),
        .Busy       (busy)
    );

    adc_serial_reader #(
        .CLK_DIV       (CD),
        .LEAD_BITS     (LB),
        .SAMPLE_PERIOD (SP2),
        .NBITS         (NB)
    ) dut2 (
        .CLK        (clk),
        .RSTn       (rstn),
        .Enable     (en2),
        .adc        (bus2),
        .Data       (data2),
        .Data_Valid (valid2),
        .Busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus2.ADC_SDO = 1'b1;

    // ---------------- ADC model: one word per frame, lead bits are junk ----------------
    logic [NB-1:0] word_q[$];
    logic [NB-1:0] cur_word = '0;
    int            bit_idx  = 0;

    function automatic logic sdo_for(input int i);
        logic [NB-1:0] tmp;
        if (i < int'(LB)) return 1'($urandom());
        if (i < int'(LB + NB)) begin
            tmp = cur_word << (i - int'(LB));
            return tmp[NB-1];
        end
        return 1'b0;
    endfunction

    always @(negedge bus.ADC_CSn) begin
        cur_word    = (word_q.size() > 0) ? word_q.pop_front() : NB'($urandom());
        bit_idx     = 0;
        bus.ADC_SDO = sdo_for(0);
    end

    always @(posedge bus.ADC_SCLK) begin
        bit_idx++;
        #1 bus.ADC_SDO = sdo_for(bit_idx);
    end

    // ---------------- Monitors (sample 1 time unit after the clock edge) ----------------
    int cyc = 0;
    int csn_falls = 0, frames_done = 0, valids = 0, rises = 0, low_len = 0;
    int last_len = 0, last_rises = 0, last_fall = 0, prev_fall = 0;
    int last_valid = 0, prev_valid = 0, busy_err = 0, dbl_valid = 0;
    logic csn_p = 1'b1, sclk_p = 1'b0, valid_p = 1'b0;

    int falls2 = 0, frames2 = 0, valids2 = 0, low2 = 0, len_err2 = 0;
    int first_fall2 = 0, last_fall2 = 0, prev_fall2 = 0, busy_err2 = 0, dbl2 = 0;
    logic csn2_p = 1'b1, valid2_p = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.ADC_CSn === 1'b0) begin
            if (csn_p === 1'b1) begin
                prev_fall = last_fall;
                last_fall = cyc;
                csn_falls++;
                low_len = 0;
                rises   = 0;
            end
            low_len++;
            if (bus.ADC_SCLK === 1'b1 && sclk_p === 1'b0) rises++;
        end else if (csn_p === 1'b0 && rstn === 1'b1) begin
            last_len   = low_len;
            last_rises = rises;
            frames_done++;
        end
        if (busy !== ~bus.ADC_CSn) busy_err++;
        if (valid === 1'b1) begin
            prev_valid = last_valid;
            last_valid = cyc;
            valids++;
            if (valid_p === 1'b1) dbl_valid++;
        end
        csn_p   = bus.ADC_CSn;
        sclk_p  = bus.ADC_SCLK;
        valid_p = valid;

        if (bus2.ADC_CSn === 1'b0) begin
            if (csn2_p === 1'b1) begin
                if (falls2 == 0) first_fall2 = cyc;
                prev_fall2 = last_fall2;
                last_fall2 = cyc;
                falls2++;
                low2 = 0;
            end
            low2++;
        end else if (csn2_p === 1'b0 && rstn === 1'b1) begin
            frames2++;
            if (low2 != int'(FRAME)) len_err2++;
        end
        if (busy2 !== ~bus2.ADC_CSn) busy_err2++;
        if (valid2 === 1'b1) begin
            valids2++;
            if (valid2_p === 1'b1) dbl2++;
        end
        csn2_p   = bus2.ADC_CSn;
        valid2_p = valid2;
    end

    // ---------------- Helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        vectors++;
        miscompares++;
        $display("FAIL %s: no event within %0d cycles", name, budget);
    endtask

    task automatic wait_falls(input int target, input int budget, input string name);
        int n = 0;
        while (csn_falls < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (csn_falls < target) timeout(name, budget);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) timeout(name, budget);
    endtask

    task automatic wait_rises(input int k, input int budget, input string name);
        int n = 0;
        while (!(bus.ADC_CSn === 1'b0 && rises >= k) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.ADC_CSn === 1'b0 && rises >= k)) timeout(name, budget);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int            t0, v0, f0, fd;
        int            sum;
        logic [NB-1:0] held;

        rstn        = 1'b1;
        en          = 1'b0;
        en2         = 1'b0;
        bus.ADC_SDO = 1'b0;
        #2 rstn = 1'b0;

        // Expected results from the frame-level rules: one word per frame, or the
        // truncated mean of each group of four when averaging.
`ifdef ADC_AVG_EN
        tab[0].word = 10'd100;
        tab[1].word = 10'd101;
        tab[2].word = 10'd102;
        tab[3].word = 10'd104;
`else
        tab[0].word = 10'h2A5;
        tab[1].word = 10'h3FF;
        tab[2].word = 10'h000;
        tab[3].word = 10'h155;
`endif
        for (int i = 4; i < int'(NVEC); i++) tab[i].word = NB'($urandom());
        sum  = 0;
        held = '0;
        for (int i = 0; i < int'(NVEC); i++) begin
            if (AVG) begin
                sum += int'(tab[i].word);
                if (i % 4 == 3) begin
                    held                = NB'(sum / 4);
                    sum                 = 0;
                    tab[i].exp_strobes  = 1;
                    tab[i].exp_gap      = (i > 3) ? 4 * int'(SP) : 0;
                end else begin
                    tab[i].exp_strobes  = 0;
                    tab[i].exp_gap      = 0;
                end
                tab[i].exp_data = held;
            end else begin
                tab[i].exp_data    = tab[i].word;
                tab[i].exp_strobes = 1;
                tab[i].exp_gap     = (i > 0) ? int'(SP) : 0;
            end
            word_q.push_back(tab[i].word);
        end

        repeat (3) @(negedge clk);
        check("reset_csn", bus.ADC_CSn, 1);
        check("reset_sclk", bus.ADC_SCLK, 0);
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);

        rstn = 1'b1;
        @(negedge clk);
        en = 1'b1;
        t0 = cyc;
        wait_falls(1, SP + 10, "first_frame_start");
        check("first_start_delay", last_fall - t0, SP);

        for (int i = 0; i < int'(NVEC); i++) begin
            v0 = valids;
            wait_frames(frames_done + 1, SP + FRAME + 10, "frame_done");
            check("data", data, tab[i].exp_data);
            check("strobes", valids - v0, tab[i].exp_strobes);
            check("csn_low_len", last_len, FRAME);
            check("sclk_rises", last_rises, LB + NB);
            if (i > 0) check("frame_spacing", last_fall - prev_fall, SP);
            if (tab[i].exp_strobes == 1) check("latency", last_valid - last_fall, FRAME);
            if (tab[i].exp_gap != 0) check("strobe_gap", last_valid - prev_valid, tab[i].exp_gap);
        end

        // Asynchronous reset at the 5th SCLK rise of a frame.
        wait_falls(csn_falls + 1, SP + 10, "reset_frame_start");
        wait_rises(5, FRAME + 10, "reset_frame_rise5");
        rstn = 1'b0;
        #1;
        check("async_rst_csn", bus.ADC_CSn, 1);
        check("async_rst_sclk", bus.ADC_SCLK, 0);
        check("async_rst_data", data, 0);
        check("async_rst_busy", busy, 0);
        v0 = valids;
        word_q.push_back(10'h1C3);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        t0   = cyc;
        f0   = csn_falls;
        wait_falls(f0 + 1, SP + 10, "restart_frame_start");
        check("restart_delay", last_fall - t0, SP);
        check("no_partial_strobe", valids - v0, 0);
        check("data_after_reset", data, 0);
        wait_frames(frames_done + 1, FRAME + 10, "restart_frame_done");
        check("restart_data", data, AVG ? 10'h000 : 10'h1C3);
        check("restart_strobes", valids - v0, AVG ? 0 : 1);

        // Enable dropped at the 6th SCLK rise: the frame still completes.
        word_q.push_back(10'h0F0);
        wait_falls(csn_falls + 1, SP + 10, "disable_frame_start");
        wait_rises(6, FRAME + 10, "disable_frame_rise6");
        en = 1'b0;
        v0 = valids;
        fd = frames_done;
        wait_frames(fd + 1, FRAME + 10, "disable_frame_done");
        check("disable_len", last_len, FRAME);
        check("disable_rises", last_rises, LB + NB);
        check("disable_strobes", valids - v0, AVG ? 0 : 1);
        check("disable_data", data, AVG ? 10'h000 : 10'h0F0);
        f0 = csn_falls;
        repeat (500) @(negedge clk);
        check("idle_while_disabled", csn_falls - f0, 0);
        check("bus_idle_csn", bus.ADC_CSn, 1);

        check("busy_tracks_csn", busy_err, 0);
        check("no_double_strobe", dbl_valid, 0);

        // Sample period shorter than a frame: every other tick is dropped.
        en2 = 1'b1;
        t0  = cyc;
        repeat (450) @(negedge clk);
        check("sp40_first_start", first_fall2 - t0, SP2);
        check("sp40_falls", falls2, 6);
        check("sp40_spacing", last_fall2 - prev_fall2, 2 * SP2);
        check("sp40_frames", frames2, 5);
        check("sp40_len_err", len_err2, 0);
        check("sp40_busy", busy_err2, 0);
        check("sp40_strobes", valids2, AVG ? 1 : 5);
        check("sp40_data", data2, 10'h3FF);
        check("sp40_no_double", dbl2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
